// File: rtl/uart_rx_core.sv
// rtl/uart_rx_core.sv - 16x-oversampled UART receiver with valid/ready output handshake.
// Optional 2-of-3 majority bit sampling when UART_RX_MAJORITY_EN is defined.
module uart_rx_core #(
    parameter int DIV_WIDTH  = 16,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rxd,
    input  logic                 enable,
    input  logic [DIV_WIDTH-1:0] baud_div,
    input  logic                 data9,
    input  logic                 parity_en,
    input  logic                 parity_odd,
    input  logic                 rx_ready,
    output logic [8:0]           rx_data,
    output logic [2:0]           rx_error,
    output logic                 rx_valid,
    output logic                 rx_done,
    output logic                 rx_busy
);

    localparam int OS_W = $clog2(OVERSAMPLE);
    localparam logic [OS_W-1:0] MID_CNT  = OS_W'(OVERSAMPLE / 2 - 1);
    localparam logic [OS_W-1:0] LAST_CNT = OS_W'(OVERSAMPLE - 1);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] START     = 3'd1;
    localparam logic [2:0] DATA      = 3'd2;
    localparam logic [2:0] PARITY    = 3'd3;
    localparam logic [2:0] STOP      = 3'd4;
    localparam logic [2:0] WAIT_HIGH = 3'd5;

    logic                 rxd_meta, rxd_s, rxd_prev;
    logic [DIV_WIDTH-1:0] div_cnt;
    logic                 tick;
    logic [2:0]           state;
    logic [OS_W-1:0]      samp_cnt;
    logic [3:0]           bit_cnt;
    logic [8:0]           shreg;
    logic                 par_acc, par_err, frame_err;
    logic                 load_pend;
    logic                 samp_bit;
    logic                 start_edge;
    logic                 bit_tick;
    logic [3:0]           last_bit;

    assign rx_busy    = (state != IDLE);
    assign start_edge = rxd_prev & ~rxd_s;
    assign bit_tick   = tick && (samp_cnt == LAST_CNT);
    assign last_bit   = data9 ? 4'd8 : 4'd7;
    assign tick       = (baud_div <= DIV_WIDTH'(1)) || (div_cnt == baud_div - DIV_WIDTH'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rxd_meta <= 1'b1;
            rxd_s    <= 1'b1;
            rxd_prev <= 1'b1;
        end else begin
            rxd_meta <= rxd;
            rxd_s    <= rxd_meta;
            rxd_prev <= rxd_s;
        end
    end

    // Held at zero in IDLE so the first tick lands a fixed distance after the start edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
        end else if (!enable || state == IDLE || tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_WIDTH'(1);
        end
    end

`ifdef UART_RX_MAJORITY_EN
    logic [1:0] hist;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist <= 2'b11;
        end else if (tick && state != IDLE) begin
            hist <= {hist[0], rxd_s};
        end
    end

    assign samp_bit = (hist[1] & hist[0]) | (hist[1] & rxd_s) | (hist[0] & rxd_s);
`else
    assign samp_bit = rxd_s;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            samp_cnt  <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            par_acc   <= 1'b0;
            par_err   <= 1'b0;
            frame_err <= 1'b0;
            load_pend <= 1'b0;
        end else begin
            load_pend <= 1'b0;
            if (!enable) begin
                state    <= IDLE;
                samp_cnt <= '0;
                bit_cnt  <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start_edge) begin
                            state    <= START;
                            samp_cnt <= '0;
                        end
                    end
                    START: begin
                        if (tick) begin
                            if (samp_cnt == MID_CNT) begin
                                samp_cnt <= '0;
                                bit_cnt  <= '0;
                                par_acc  <= 1'b0;
                                par_err  <= 1'b0;
                                state    <= samp_bit ? IDLE : DATA;
                            end else begin
                                samp_cnt <= samp_cnt + OS_W'(1);
                            end
                        end
                    end
                    DATA: begin
                        if (tick) samp_cnt <= samp_cnt + OS_W'(1);
                        if (bit_tick) begin
                            shreg   <= {samp_bit, shreg[8:1]};
                            par_acc <= par_acc ^ samp_bit;
                            if (bit_cnt == last_bit) begin
                                bit_cnt <= '0;
                                state   <= parity_en ? PARITY : STOP;
                            end else begin
                                bit_cnt <= bit_cnt + 4'd1;
                            end
                        end
                    end
                    PARITY: begin
                        if (tick) samp_cnt <= samp_cnt + OS_W'(1);
                        if (bit_tick) begin
                            par_err <= (par_acc ^ samp_bit) != parity_odd;
                            state   <= STOP;
                        end
                    end
                    STOP: begin
                        if (tick) samp_cnt <= samp_cnt + OS_W'(1);
                        if (bit_tick) begin
                            frame_err <= ~samp_bit;
                            load_pend <= 1'b1;
                            state     <= samp_bit ? IDLE : WAIT_HIGH;
                        end
                    end
                    WAIT_HIGH: begin
                        if (rxd_s) state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // In 8-bit mode the word sits in shreg[8:1] after eight right shifts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_data  <= '0;
            rx_error <= '0;
            rx_valid <= 1'b0;
            rx_done  <= 1'b0;
        end else begin
            rx_done <= load_pend;
            if (load_pend) begin
                rx_data  <= data9 ? shreg : {1'b0, shreg[8:1]};
                rx_error <= {rx_valid & ~rx_ready, frame_err, par_err};
                rx_valid <= 1'b1;
            end else if (rx_valid && rx_ready) begin
                rx_valid    <= 1'b0;
                rx_error[2] <= 1'b0;
            end
        end
    end

endmodule
